div_ratio_ctrl: RTL

- Runtime-reconfigurable clock-divider controller for the Tiny-PLL feedback and output path.
- Owns the divide counter and the active ratio. Accepts new ratios over a valid/ready handshake.
- Switches ratio only at an output-period boundary, so no runt pulse is produced. After each switch it waits a settle window before asserting `locked`.
- Sits between the configuration logic and the PLL phase detector / output clock tree.

---
 rtl/tiny_pll_pkg.sv | 26 ++
 rtl/div_ratio_ctrl_core.sv | 41 ++++
 rtl/div_ratio_ctrl.sv | 107 ++++++++++
 3 files changed

// File: rtl/tiny_pll_pkg.sv
// Shared Tiny-PLL types and constants.
// Holds the divider FSM state type, MIN_DIV and the parameter-check function.
package tiny_pll_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_PEND   = 2'd1,
    ST_SETTLE = 2'd2
  } div_state_e;

  localparam int MIN_DIV = 2;

  // True when a divider configuration is usable: the default ratio fits
  // the counter and is at least MIN_DIV, and the settle window is non-empty.
  function automatic bit div_params_ok(
    input int     cnt_w,
    input longint def_div,
    input int     settle
  );
    longint max_div;
    if (cnt_w < 1 || cnt_w > 32) return 1'b0;
    max_div = (longint'(1) << cnt_w) - 1;
    return (def_div >= MIN_DIV) && (def_div <= max_div) && (settle >= 1);
  endfunction

endpackage

// File: rtl/div_ratio_ctrl_core.sv
// Divide counter plus registered divided clock.
// Ports: clk_in/rst, div_value (ratio N), load (force cnt to 0), wrap, clk_out.
module div_core #(
  parameter int CNT_W = 8
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic [CNT_W-1:0] div_value,
  input  logic             load,
  output logic             wrap,
  output logic             clk_out
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] half;
  logic             clk_q;

  // cnt never exceeds N-1, so the compare needs no overflow guard.
  assign wrap = (cnt_q == div_value - CNT_W'(1));
  assign half = div_value >> 1;

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (wrap || load) cnt_d = '0;
  end

  // clk_out follows the next count: low for H cycles, high for N-H.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      clk_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      clk_q <= (cnt_d >= half);
    end
  end

  assign clk_out = clk_q;

endmodule

// File: rtl/div_ratio_ctrl.sv
// Runtime-reconfigurable clock-divider controller for the Tiny-PLL.
// Ports: cfg_valid/cfg_div/cfg_ready/cfg_err handshake, clk_out, locked, busy, active_div.
module div_ratio_ctrl
  import tiny_pll_pkg::*;
#(
  parameter int CNT_W         = 8,
  parameter int DEFAULT_DIV   = 4,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             cfg_valid,
  input  logic [CNT_W-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic             clk_out,
  output logic             locked,
  output logic             busy,
  output logic [CNT_W-1:0] active_div
);

  if (!div_params_ok(CNT_W, longint'(DEFAULT_DIV), SETTLE_CYCLES)) begin : g_bad_params
    $error("div_ratio_ctrl: illegal DEFAULT_DIV/SETTLE_CYCLES/CNT_W");
  end

  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);

  div_state_e       state_q, state_d;
  logic [SW-1:0]    settle_q, settle_d;
  logic [CNT_W-1:0] active_q, active_d;
  logic [CNT_W-1:0] pend_q, pend_d;
  logic             err_q, err_d;
  logic             load;
  logic             wrap;

  div_core #(
    .CNT_W(CNT_W)
  ) u_core (
    .clk_in   (clk_in),
    .rst      (rst),
    .div_value(active_q),
    .load     (load),
    .wrap     (wrap),
    .clk_out  (clk_out)
  );

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    active_d = active_q;
    pend_d   = pend_q;
    err_d    = 1'b0;
    load     = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        if (cfg_valid && cfg_ready) begin
          if (cfg_div < CNT_W'(MIN_DIV)) begin
            err_d = 1'b1;
          end else if (cfg_div != active_q) begin
            pend_d  = cfg_div;
            state_d = ST_PEND;
          end
        end
      end
      // Swap only at a wrap so the old period finishes in full.
      ST_PEND: begin
        if (wrap) begin
          active_d = pend_q;
          load     = 1'b1;
          settle_d = '0;
          state_d  = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (wrap) begin
          if (settle_q == SETTLE_LAST) state_d = ST_RUN;
          else settle_d = settle_q + SW'(1);
        end
      end
      default: state_d = ST_SETTLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state_q  <= ST_SETTLE;
      settle_q <= '0;
      active_q <= CNT_W'(DEFAULT_DIV);
      pend_q   <= CNT_W'(DEFAULT_DIV);
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      active_q <= active_d;
      pend_q   <= pend_d;
      err_q    <= err_d;
    end
  end

  assign cfg_ready  = (state_q == ST_RUN);
  assign locked     = (state_q == ST_RUN);
  assign busy       = (state_q != ST_RUN);
  assign cfg_err    = err_q;
  assign active_div = active_q;

endmodule
